frame_sequencer: RTL and testbench

Per-frame scheduler for the game datapath: derives the frame tick from the 50 MHz clock, fires one game-logic step per frame, then drives a single raster sweep of pixel coordinates with a plot strobe into the VGA adapter. Sits between the game controller (enable/freeze) and the logic and renderer blocks. Guarantees logic never updates mid-sweep, and reports dropped frames and hung logic steps.

---
 rtl/frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler. Derives the frame tick, fires one
// game-logic step per frame, then sweeps every pixel coordinate once with a
// plot strobe. Dropped ticks and hung logic steps are reported.
module frame_sequencer #(
    parameter int unsigned FRAME_CYCLES  = 833334,
    parameter int unsigned XMAX          = 159,
    parameter int unsigned YMAX          = 119,
    parameter int unsigned LOGIC_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       freeze,
    input  logic       logic_done,
    output logic       logic_step,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       plot,
    output logic       frame_done,
    output logic       busy,
    output logic       logic_timeout,
    output logic [7:0] overrun_count
);

    localparam int unsigned TICK_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned WAIT_W = $clog2(LOGIC_TIMEOUT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOGIC_TIMEOUT);
    localparam logic [7:0]        X_LAST    = 8'(XMAX);
    localparam logic [7:0]        Y_LAST    = 8'(YMAX);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOGIC      = 3'd1,
        S_LOGIC_WAIT = 3'd2,
        S_RENDER     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t            r_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_logic_step;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic              r_plot;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_logic_timeout;
    logic [7:0]        r_overrun_count;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running frame tick counter, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Frame FSM with registered outputs; outputs are set on the transition
    // into the state that owns them so they line up with that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_logic_step    <= 1'b0;
            r_x             <= 8'd0;
            r_y             <= 8'd0;
            r_plot          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_busy          <= 1'b0;
            r_logic_timeout <= 1'b0;
            r_overrun_count <= 8'd0;
        end else begin
            r_logic_step <= 1'b0;
            r_frame_done <= 1'b0;

            // A tick that arrives while a frame is in flight is dropped.
            if (w_tick && (r_state != S_IDLE) && (r_overrun_count != 8'hFF)) begin
                r_overrun_count <= r_overrun_count + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick && enable) begin
                        r_busy <= 1'b1;
                        if (freeze) begin
                            r_state <= S_RENDER;
                            r_plot  <= 1'b1;
                            r_x     <= 8'd0;
                            r_y     <= 8'd0;
                        end else begin
                            r_state      <= S_LOGIC;
                            r_logic_step <= 1'b1;
                        end
                    end
                end
                S_LOGIC: begin
                    // Counter holds the number of wait cycles including the current one.
                    r_state    <= S_LOGIC_WAIT;
                    r_wait_cnt <= WAIT_W'(1);
                end
                S_LOGIC_WAIT: begin
                    if (logic_done) begin
                        r_state <= S_RENDER;
                        r_plot  <= 1'b1;
                        r_x     <= 8'd0;
                        r_y     <= 8'd0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state         <= S_RENDER;
                        r_plot          <= 1'b1;
                        r_x             <= 8'd0;
                        r_y             <= 8'd0;
                        r_logic_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_RENDER: begin
                    if (r_x == X_LAST) begin
                        r_x <= 8'd0;
                        if (r_y == Y_LAST) begin
                            r_state      <= S_DONE;
                            r_plot       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_y          <= 8'd0;
                        end else begin
                            r_y <= r_y + 8'd1;
                        end
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

    assign logic_step    = r_logic_step;
    assign x             = r_x;
    assign y             = r_y;
    assign plot          = r_plot;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;
    assign logic_timeout = r_logic_timeout;
    assign overrun_count = r_overrun_count;

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: scoreboard of expected step/pixel/done
// events per frame, plus a short-frame instance for overrun saturation.
module tb_frame_sequencer;

    localparam int NPIX = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, freeze, logic_done;
    logic       logic_step, plot, frame_done, busy, logic_timeout;
    logic [7:0] x, y, overrun_count;

    logic       reset2, logic_done2;
    logic       logic_step2, plot2, frame_done2, busy2, logic_timeout2;
    logic [7:0] x2, y2, overrun_count2;

    int n_checks = 0;
    int n_fails  = 0;

    frame_sequencer #(.FRAME_CYCLES(64), .XMAX(3), .YMAX(2), .LOGIC_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .freeze(freeze),
        .logic_done(logic_done), .logic_step(logic_step), .x(x), .y(y),
        .plot(plot), .frame_done(frame_done), .busy(busy),
        .logic_timeout(logic_timeout), .overrun_count(overrun_count)
    );

    frame_sequencer #(.FRAME_CYCLES(16), .XMAX(3), .YMAX(2), .LOGIC_TIMEOUT(8)) dut2 (
        .clk(clk), .reset(reset2), .enable(1'b1), .freeze(1'b0),
        .logic_done(logic_done2), .logic_step(logic_step2), .x(x2), .y(y2),
        .plot(plot2), .frame_done(frame_done2), .busy(busy2),
        .logic_timeout(logic_timeout2), .overrun_count(overrun_count2)
    );

    // Cycle number since the last reset edge; matches the DUT tick counter.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Logic block model: done 3 cycles after step (main), 5 cycles (short-frame).
    logic       resp_en = 1'b1;
    logic [2:0] r_resp  = '0;
    logic [4:0] r_resp2 = '0;
    always @(posedge clk) begin
        r_resp  <= {r_resp[1:0], logic_step};
        r_resp2 <= {r_resp2[3:0], logic_step2};
    end
    assign logic_done  = resp_en & r_resp[2];
    assign logic_done2 = r_resp2[4];

    typedef struct {
        int         cyc;
        logic       step;
        logic       plot;
        logic       fd;
        logic [7:0] x;
        logic [7:0] y;
    } ev_t;

    ev_t exp_q[$];

    // Queue the expected events of one frame whose tick is in cycle t.
    task automatic push_frame(input int t, input int first_plot, input bit with_step);
        ev_t e;
        if (with_step) begin
            e.cyc = t + 1; e.step = 1'b1; e.plot = 1'b0; e.fd = 1'b0; e.x = 8'd0; e.y = 8'd0;
            exp_q.push_back(e);
        end
        for (int yy = 0; yy <= 2; yy++) begin
            for (int xx = 0; xx <= 3; xx++) begin
                e.cyc = t + first_plot + yy * 4 + xx;
                e.step = 1'b0; e.plot = 1'b1; e.fd = 1'b0;
                e.x = 8'(xx); e.y = 8'(yy);
                exp_q.push_back(e);
            end
        end
        e.cyc = t + first_plot + NPIX; e.step = 1'b0; e.plot = 1'b0; e.fd = 1'b1;
        e.x = 8'd0; e.y = 8'd0;
        exp_q.push_back(e);
    endtask

    // Advance to cycle c, comparing every output event against the scoreboard.
    task automatic observe_to(input int c);
        ev_t e;
        while (cyc < c) begin
            @(negedge clk);
            if (logic_step || plot || frame_done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL event: got step=%0b plot=%0b fd=%0b (%0d,%0d) at cycle %0d, required no event",
                             logic_step, plot, frame_done, x, y, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || logic_step !== e.step || plot !== e.plot ||
                        frame_done !== e.fd || x !== e.x || y !== e.y) begin
                        n_fails++;
                        $display("FAIL event: got cyc=%0d step=%0b plot=%0b fd=%0b (%0d,%0d), required cyc=%0d step=%0b plot=%0b fd=%0b (%0d,%0d)",
                                 cyc, logic_step, plot, frame_done, x, y,
                                 e.cyc, e.step, e.plot, e.fd, e.x, e.y);
                    end
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fails++;
            $display("FAIL %s_drained: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; reset2 = 1'b1; enable = 1'b0; freeze = 1'b0; resp_en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({logic_step, plot, frame_done, busy, logic_timeout} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got step/plot/fd/busy/to=%b, required 00000",
                     {logic_step, plot, frame_done, busy, logic_timeout});
        end
        n_checks++;
        if ({x, y, overrun_count} !== 24'd0) begin
            n_fails++;
            $display("FAIL reset_values: got x=%0d y=%0d ovr=%0d, required 0 0 0", x, y, overrun_count);
        end
        enable = 1'b1;
        reset  = 1'b0;
    endtask

    task automatic test_normal;
        push_frame(63, 5, 1'b1);
        push_frame(127, 5, 1'b1);
        observe_to(150);
        check_drained("normal");
        n_checks++;
        if (overrun_count !== 8'd0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL normal_idle: got ovr=%0d busy=%0b, required 0 0", overrun_count, busy);
        end
    endtask

    task automatic test_freeze;
        freeze = 1'b1;
        push_frame(191, 1, 1'b0);
        observe_to(210);
        freeze = 1'b0;
        check_drained("freeze");
    endtask

    task automatic test_timeout;
        resp_en = 1'b0;
        push_frame(255, 10, 1'b1);
        observe_to(264);
        n_checks++;
        if (logic_timeout !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_early: got %0b at cycle %0d, required 0", logic_timeout, cyc);
        end
        observe_to(265);
        n_checks++;
        if (logic_timeout !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_set: got %0b at cycle %0d, required 1", logic_timeout, cyc);
        end
        resp_en = 1'b1;
        push_frame(319, 5, 1'b1);
        observe_to(345);
        check_drained("timeout");
        n_checks++;
        if (logic_timeout !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_sticky: got %0b, required 1", logic_timeout);
        end
    endtask

    task automatic test_enable;
        enable = 1'b0;
        observe_to(400);
        n_checks++;
        if (overrun_count !== 8'd0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL disabled_tick: got ovr=%0d busy=%0b, required 0 0", overrun_count, busy);
        end
        enable = 1'b1;
        push_frame(447, 5, 1'b1);
        observe_to(455);
        enable = 1'b0;
        freeze = 1'b1;
        observe_to(470);
        check_drained("enable_drop");
        n_checks++;
        if (overrun_count !== 8'd0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL enable_drop_end: got ovr=%0d busy=%0b, required 0 0", overrun_count, busy);
        end
        enable = 1'b1;
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid;
        push_frame(511, 5, 1'b1);
        observe_to(522);
        n_checks++;
        if (plot !== 1'b1 || x !== 8'd2 || y !== 8'd1) begin
            n_fails++;
            $display("FAIL mid_pixel: got plot=%0b (%0d,%0d), required 1 (2,1)", plot, x, y);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if ({logic_step, plot, frame_done, busy, logic_timeout} !== 5'b0) begin
            n_fails++;
            $display("FAIL midreset_flags: got step/plot/fd/busy/to=%b, required 00000",
                     {logic_step, plot, frame_done, busy, logic_timeout});
        end
        n_checks++;
        if ({x, y, overrun_count} !== 24'd0) begin
            n_fails++;
            $display("FAIL midreset_values: got x=%0d y=%0d ovr=%0d, required 0 0 0", x, y, overrun_count);
        end
        reset = 1'b0;
        push_frame(63, 5, 1'b1);
        observe_to(85);
        check_drained("after_reset");
    endtask

    task automatic test_overrun;
        int fds   = 0;
        int plots = 0;
        reset2 = 1'b1;
        repeat (2) @(negedge clk);
        reset2 = 1'b0;
        for (int c = 1; c <= 9620; c++) begin
            @(negedge clk);
            if (frame_done2) fds++;
            if (plot2) plots++;
            if (c == 22) begin
                n_checks++;
                if (plot2 !== 1'b1 || busy2 !== 1'b1 || x2 !== 8'd0 || y2 !== 8'd0) begin
                    n_fails++;
                    $display("FAIL short_first_plot: got plot=%0b busy=%0b (%0d,%0d), required 1 1 (0,0)",
                             plot2, busy2, x2, y2);
                end
            end
            if (c == 31 || c == 32 || c == 8159 || c == 8160) begin
                n_checks++;
                if (overrun_count2 !== ((c == 31) ? 8'd0 : (c == 32) ? 8'd1 : (c == 8159) ? 8'd254 : 8'd255)) begin
                    n_fails++;
                    $display("FAIL overrun_c%0d: got %0d, required %0d", c, overrun_count2,
                             (c == 31) ? 0 : (c == 32) ? 1 : (c == 8159) ? 254 : 255);
                end
            end
        end
        n_checks++;
        if (overrun_count2 !== 8'd255) begin
            n_fails++;
            $display("FAIL overrun_saturate: got %0d, required 255", overrun_count2);
        end
        n_checks++;
        if (fds !== 300 || plots !== 300 * NPIX || logic_timeout2 !== 1'b0) begin
            n_fails++;
            $display("FAIL short_frames: got fd=%0d plots=%0d to=%0b, required 300 %0d 0",
                     fds, plots, logic_timeout2, 300 * NPIX);
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_freeze;
        test_timeout;
        test_enable;
        test_reset_mid;
        test_overrun;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
